// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  // Quotient on divide-by-zero; sliced to W bits at the use site (W <= 64).
  localparam int            DIV0_MAX_W = 64;
  localparam logic [DIV0_MAX_W-1:0] DIV0_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_r,
  input  logic         i_a_msb,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_r_next,
  output logic         o_q_bit
);

  logic [W:0]   w_shift;
  logic [W-1:0] w_diff;

  // The partial remainder is always < B, so the shifted value needs W+1 bits
  // but the difference and the restored value both fit back into W bits.
  assign w_shift  = {i_r, i_a_msb};
  assign w_diff   = w_shift[W-1:0] - i_b;
  assign o_q_bit  = (w_shift >= {1'b0, i_b});
  assign o_r_next = o_q_bit ? w_diff : w_shift[W-1:0];

endmodule

// File: rtl/iterative_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock, one division in flight.
module iterative_divider
  import div_pkg::*;
#(
  parameter  int W     = 32,
  localparam int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_div_i,
  input  logic [W-1:0] Data_A_i,
  input  logic [W-1:0] Data_B_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic [W-1:0] Data_Q_o,
  output logic [W-1:0] Data_R_o,
  output logic         div_zero_o
);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_rem;

  logic [W-1:0]     w_r_next;
  logic             w_q_bit;

  div_step #(.W(W)) u_step (
    .i_r      (r_rem),
    .i_a_msb  (r_a[W-1]),
    .i_b      (r_b),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  // r_a doubles as the quotient register: dividend bits leave at the MSB
  // while quotient bits enter at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      busy_o     <= 1'b0;
      ready_o    <= 1'b0;
      Data_Q_o   <= '0;
      Data_R_o   <= '0;
      div_zero_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (beg_div_i) begin
            r_a    <= Data_A_i;
            r_b    <= Data_B_i;
            r_rem  <= '0;
            r_cnt  <= CNT_W'(W);
            busy_o <= 1'b1;
            if (Data_B_i == '0) begin
              r_state    <= DONE;
              ready_o    <= 1'b1;
              Data_Q_o   <= DIV0_Q[W-1:0];
              Data_R_o   <= Data_A_i;
              div_zero_o <= 1'b1;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_r_next;
          r_a   <= {r_a[W-2:0], w_q_bit};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state    <= DONE;
            ready_o    <= 1'b1;
            Data_Q_o   <= {r_a[W-2:0], w_q_bit};
            Data_R_o   <= w_r_next;
            div_zero_o <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed + random bench for iterative_divider with a result scoreboard.
module tb_iterative_divider;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         beg_div_i = 1'b0;
  logic [W-1:0] Data_A_i = '0;
  logic [W-1:0] Data_B_i = '0;
  logic         busy_o, ready_o, div_zero_o;
  logic [W-1:0] Data_Q_o, Data_R_o;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  logic prev_ready = 1'b0;

  iterative_divider #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .beg_div_i  (beg_div_i),
    .Data_A_i   (Data_A_i),
    .Data_B_i   (Data_B_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .Data_Q_o   (Data_Q_o),
    .Data_R_o   (Data_R_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    if (b == '0) begin
      m.q = '1; m.r = a; m.dz = 1'b1;
    end else begin
      m.q = a / b; m.r = a % b; m.dz = 1'b0;
    end
    return m;
  endfunction

  // Scoreboard side: every ready pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (ready_o) begin
        chk("ready_twice", 64'(prev_ready), 64'd0);
        chk("unexpected_ready", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          res_t e;
          e = sb.pop_front();
          chk("sb_q",  64'(Data_Q_o),   64'(e.q));
          chk("sb_r",  64'(Data_R_o),   64'(e.r));
          chk("sb_dz", 64'(div_zero_o), 64'(e.dz));
        end
      end
      prev_ready = ready_o;
    end
  end

  // All driving happens #1 after a rising edge; e counts edges since acceptance.
  task automatic step(inout int e);
    @(posedge clk); #1; e++;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int e);
    sb.push_back(model(a, b));
    beg_div_i = 1'b1; Data_A_i = a; Data_B_i = b;
    e = 0;
    step(e);
    beg_div_i = 1'b0; Data_A_i = $urandom; Data_B_i = $urandom;
  endtask

  task automatic wait_ready(inout int e, output int nbusy);
    int lim;
    lim = e + 100;
    nbusy = 0;
    if (busy_o) nbusy++;
    while (!ready_o && e < lim) begin
      step(e);
      if (busy_o) nbusy++;
    end
    chk("ready_timeout", 64'(ready_o), 64'd1);
  endtask

  initial begin
    int e, nb, e1;
    logic [W-1:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(busy_o),     64'd0);
    chk("rst_ready", 64'(ready_o),    64'd0);
    chk("rst_q",     64'(Data_Q_o),   64'd0);
    chk("rst_r",     64'(Data_R_o),   64'd0);
    chk("rst_dz",    64'(div_zero_o), 64'd0);
    rst = 1'b0;
    e = 0; step(e);

    // 1: 100/7, latency and busy window
    issue(32'd100, 32'd7, e);
    wait_ready(e, nb);
    chk("t1_lat",  64'(e),  64'd33);
    chk("t1_busy", 64'(nb), 64'd33);
    step(e);
    chk("t1_busy_off", 64'(busy_o),   64'd0);
    chk("t1_hold_q",   64'(Data_Q_o), 64'd14);

    // 2: divide by zero, then a normal result clears div_zero_o
    issue(32'd5, 32'd0, e);
    wait_ready(e, nb);
    chk("t2_lat0", 64'(e), 64'd1);
    step(e);
    chk("t2_hold_dz", 64'(div_zero_o), 64'd1);
    issue(32'd8, 32'd2, e);
    wait_ready(e, nb);
    chk("t2_lat", 64'(e), 64'd33);
    step(e);

    // 3: boundary operands
    issue(32'hFFFF_FFFF, 32'd1, e);
    wait_ready(e, nb);
    step(e);
    issue(32'd3, 32'd10, e);
    wait_ready(e, nb);
    step(e);

    // 4: start while busy is ignored
    issue(32'd1000, 32'd3, e);
    repeat (8) step(e);
    beg_div_i = 1'b1; Data_A_i = 32'd9; Data_B_i = 32'd9;
    step(e);
    beg_div_i = 1'b0;
    chk("t4_edge", 64'(e), 64'd10);
    wait_ready(e, nb);
    chk("t4_lat", 64'(e), 64'd33);
    step(e);

    // 5: reset mid-division aborts with no result
    beg_div_i = 1'b1; Data_A_i = 32'd1000; Data_B_i = 32'd3;
    e = 0; step(e);
    beg_div_i = 1'b0;
    repeat (13) step(e);
    rst = 1'b1;
    step(e);
    chk("t5_edge",  64'(e),          64'd15);
    chk("t5_busy",  64'(busy_o),     64'd0);
    chk("t5_ready", 64'(ready_o),    64'd0);
    chk("t5_q",     64'(Data_Q_o),   64'd0);
    chk("t5_r",     64'(Data_R_o),   64'd0);
    chk("t5_dz",    64'(div_zero_o), 64'd0);
    rst = 1'b0;
    repeat (40) step(e);
    chk("t5_no_ready", 64'(sb.size()), 64'd0);
    issue(32'd50, 32'd5, e);
    wait_ready(e, nb);
    step(e);

    // 6: back-to-back with beg_div_i held high
    sb.push_back(model(32'd77, 32'd8));
    sb.push_back(model(32'd64, 32'd4));
    beg_div_i = 1'b1; Data_A_i = 32'd77; Data_B_i = 32'd8;
    e = 0; step(e);
    Data_A_i = 32'd64; Data_B_i = 32'd4;
    wait_ready(e, nb);
    e1 = e;
    step(e);
    chk("t6_idle_gap", 64'(busy_o), 64'd0);
    step(e);
    beg_div_i = 1'b0;
    chk("t6_reaccept", 64'(busy_o), 64'd1);
    wait_ready(e, nb);
    chk("t6_spacing", 64'(e - e1), 64'd34);
    step(e);

    // Random pairs against the A/B, A%B model
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = W'($urandom_range(1, 255));
        2:       b = (i % 20 == 2) ? '0 : a >> $urandom_range(0, 31);
        default: b = W'($urandom_range(0, 3));
      endcase
      issue(a, b, e);
      wait_ready(e, nb);
      chk("rnd_lat", 64'(e), (b == '0) ? 64'd1 : 64'd33);
      step(e);
    end

    repeat (3) step(e);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
